// File: rtl/queue_rr_arbiter_pkg.sv
// Shared helpers for the round-robin queue arbiter: index width, modulo-N
// increment and grant reset value.
package queue_rr_arbiter_pkg;

  localparam int unsigned GrantRst = 0;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Explicit modulo so non-power-of-two requester counts wrap correctly.
  function automatic int unsigned next_idx(input int unsigned i, input int unsigned n);
    return (i + 1) % n;
  endfunction

endpackage

// File: rtl/queue_rr_arbiter_if.sv
// Requester and queue-enqueue bundle seen by the arbiter.
interface queue_rr_arbiter_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 4
) ();
  import queue_rr_arbiter_pkg::*;

  localparam int unsigned IW = idx_width(N);

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [IW-1:0]  out_grant;

  // Arbiter side.
  modport master (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_grant
  );

  // Requesters plus queue side.
  modport slave (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_grant
  );

endinterface

// File: rtl/queue_rr_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first valid requester starting at ptr_i.
module rr_priority_pick
  import queue_rr_arbiter_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req_valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] winner_o,
  output logic          found_o
);

  logic          found;
  logic [IW-1:0] win;
  int unsigned   idx;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(ptr_i) + off) % N;
      if (!found && req_valid_i[IW'(idx)]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign winner_o = win;
  assign found_o  = found;

endmodule

// File: rtl/queue_rr_arbiter.sv
// Round-robin arbiter feeding a queue enqueue port through a single-entry
// registered output stage; full throughput, one cycle latency.
module queue_rr_arbiter
  import queue_rr_arbiter_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 4
) (
  input logic               clk,
  input logic               reset,
  queue_rr_arbiter_if.master bus
);

  localparam int unsigned IW = idx_width(N);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          valid_q, valid_d;
  logic [W-1:0]  data_q, data_d;
  logic [IW-1:0] grant_q, grant_d;

  logic [IW-1:0] winner;
  logic          found;
  logic          load;
  logic [W-1:0]  win_data;

  rr_priority_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req_valid_i (bus.req_valid),
    .ptr_i       (ptr_q),
    .winner_o    (winner),
    .found_o     (found)
  );

  assign load = !valid_q || bus.out_ready;

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (winner == IW'(i)) win_data = bus.req_data[i*W +: W];
    end
  end

  // Grants are suppressed while reset is asserted, even though the stage is empty.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      bus.req_ready[i] = load && found && !reset && (winner == IW'(i));
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    grant_d = grant_q;
    if (load) begin
      valid_d = found;
      if (found) begin
        data_d  = win_data;
        grant_d = winner;
        ptr_d   = IW'(next_idx(32'(winner), N));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      grant_q <= IW'(GrantRst);
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      grant_q <= grant_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_grant = grant_q;

endmodule

// File: tb/tb_queue_rr_arbiter.sv
// Directed and random checks of queue_rr_arbiter against a cycle-level
// reference model of the round-robin and output-stage rules.
module tb_queue_rr_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  queue_rr_arbiter_if #(.N(N), .W(W)) bus ();

  queue_rr_arbiter #(.N(N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference state
  int         m_ptr;
  bit         m_valid;
  logic [W-1:0] m_data;
  int         m_grant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_data  = '0;
    m_grant = 0;
  endtask

  function automatic int pick(input logic [N-1:0] v);
    for (int off = 0; off < int'(N); off++) begin
      if (v[(m_ptr + off) % int'(N)]) return (m_ptr + off) % int'(N);
    end
    return -1;
  endfunction

  // Drive one cycle of inputs, check req_ready, clock, then check the stage.
  task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, input bit ordy,
                       input string tag);
    int w;
    bit load;
    logic [N-1:0] exp_rdy;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.out_ready = ordy;
    #1;
    load    = !m_valid || ordy;
    w       = pick(v);
    exp_rdy = (load && w >= 0) ? (N'(1) << w) : '0;
    chk($sformatf("%s.req_ready", tag), 32'(bus.req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (load) begin
      m_valid = (w >= 0);
      if (w >= 0) begin
        m_data  = d[w*W +: W];
        m_grant = w;
        m_ptr   = (w + 1) % int'(N);
      end
    end
    #1;
    chk($sformatf("%s.out_valid", tag), 32'(bus.out_valid), 32'(m_valid));
    chk($sformatf("%s.out_data", tag), 32'(bus.out_data), 32'(m_data));
    chk($sformatf("%s.out_grant", tag), 32'(bus.out_grant), 32'(m_grant));
  endtask

  task automatic sync_reset_pulse();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  localparam logic [N*W-1:0] Data1234 = {4'h4, 4'h3, 4'h2, 4'h1};

  initial begin
    model_reset();
    reset         = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_data  = Data1234;
    bus.out_ready = 1'b1;

    // 1. Reset held two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.out_grant", 32'(bus.out_grant), 32'd0);
    chk("rst.out_data", 32'(bus.out_data), 32'd0);
    chk("rst.req_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;

    // 2. Round-robin with all valid; one extra grant leaves data=2, grant=1, ptr=2
    for (int i = 0; i < 6; i++) begin
      cycle(4'b1111, Data1234, 1'b1, $sformatf("rr%0d", i));
      chk($sformatf("rr%0d.grant_seq", i), 32'(bus.out_grant), 32'(i % 4));
    end

    // 3. Back-pressure for three cycles, then release with no bubble
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, Data1234, 1'b0, $sformatf("bp%0d", i));
      chk($sformatf("bp%0d.hold_data", i), 32'(bus.out_data), 32'd2);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(bus.req_ready), 32'b0100);
    cycle(4'b1111, Data1234, 1'b1, "bp_rel");
    chk("bp_rel.grant", 32'(bus.out_grant), 32'd2);

    // 4. Sparse requests from ptr=0
    sync_reset_pulse();
    cycle(4'b1000, 16'h9000, 1'b1, "sp3");
    chk("sp3.data9", 32'(bus.out_data), 32'h9);
    cycle(4'b0010, 16'h0050, 1'b1, "sp1");
    chk("sp1.grant1", 32'(bus.out_grant), 32'd1);

    // 5. Idle drain: valid falls, data/grant hold, ptr unchanged
    cycle(4'b0000, 16'h0000, 1'b1, "idle");
    chk("idle.valid0", 32'(bus.out_valid), 32'd0);
    cycle(4'b1111, Data1234, 1'b1, "idle_next");

    // 6. Asynchronous reset between edges while the stage is full
    cycle(4'b1111, Data1234, 1'b0, "pre_arst");
    #2;
    reset = 1'b1;
    #1;
    chk("arst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst.out_grant", 32'(bus.out_grant), 32'd0);
    chk("arst.req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cycle(4'b1111, Data1234, 1'b1, "post_arst");
    chk("post_arst.grant0", 32'(bus.out_grant), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(N'($urandom), (N*W)'($urandom), ($urandom_range(0, 3) != 0),
            $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/queue_rr_arbiter.md
Name: queue_rr_arbiter

Overview:
- Shares the enqueue side of a single 4-bit queue between N requesters using round-robin arbitration.
- Sits directly in front of the queue's enq/din/enq_ready port and registers one winning word per cycle into a single-entry output stage.
- Provides full throughput (one transfer per cycle) with 1-cycle latency.
- Reports which requester owns the word presented downstream.

Parameters:
N, 4, number of requesters (2..8)
W, 4, data width per requester; matches queue data width
IW, $clog2(N), width of the grant index

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
req_valid  input  N  per-requester valid
req_data  input  N*W  packed data; requester i occupies bits [i*W +: W]
req_ready  output  N  per-requester accept; one-hot or zero
out_valid  output  1  drives queue enq
out_data  output  W  drives queue din
out_ready  input  1  from queue enq_ready
out_grant  output  IW  index of requester whose word is in out_data

Behaviour:
- Reset (asynchronous, active-high, any time): out_valid=0, out_data=0, out_grant=0, priority pointer ptr=0. Any word held in the output stage is discarded.
- Output stage is one register (valid, data, grant index).
- load = !out_valid || out_ready. This is the combinational "stage empty or draining" signal.
- Winner: the first i with req_valid[i]=1, scanning ptr, ptr+1, … modulo N. There is no winner if no req_valid bit is set.
- req_ready[i] = load && (winner==i). req_ready is combinational from req_valid, out_valid and out_ready. It must not depend on req_data.
- A transfer occurs for requester i when req_valid[i] && req_ready[i].
  - On the next edge: out_valid=1, out_data=req_data[i], out_grant=i, ptr=(i+1) mod N.
- If load=1 and no requester is valid: out_valid becomes 0 on the next edge. out_data and out_grant hold their last values.
- If load=0 (out_valid=1, out_ready=0):
  - The stage holds.
  - ptr is unchanged.
  - All req_ready bits are 0.
- ptr advances only on a transfer, never on idle cycles.
- Simultaneous drain and refill (out_valid && out_ready && some req_valid): the new word loads in the same edge, so there is no bubble.
- Latency: a word accepted at edge k appears on out_data after edge k. It is consumed by the queue at the first edge where out_ready=1.
- Fairness: with all N requesters continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0,…
  - Each requester is served once per N transfers.
- Requester rules:
  - A requester may drop req_valid without a transfer; the arbiter keeps no memory of it.
  - The data of a requester that loses arbitration is not captured.
- Wrap-around: ptr=N-1 followed by a grant to N-1 sets ptr=0.
  - The modulo is explicit so that N values other than powers of two work.
- Back-pressure from a full queue propagates combinationally to all req_ready bits in the same cycle.

Decomposition:
- Shared package holds:
  - the grant index width function;
  - the round-robin "next index" helper (i+1 mod N);
  - the reset value of the grant index (0).
- One natural sub-module, rr_priority_pick. It is purely combinational:
  - inputs: req_valid and ptr;
  - outputs: winner index and a found flag.
- The top level owns ptr and the output register.

Test Plan:
1. Reset: assert reset for 2 cycles with req_valid=4'b1111. Require out_valid=0, out_grant=0 and req_ready=0 during reset. After release, the first grant is requester 0.
2. Round-robin: all four requesters valid with data 1,2,3,4 and out_ready=1.
   - Require req_ready to be 0001, 0010, 0100, 1000, 0001 on successive cycles.
   - Require out_data to be 1,2,3,4,1 with a 1-cycle lag.
   - Require out_grant to be 0,1,2,3,0.
3. Back-pressure: with the stage holding data=2, grant=1, drop out_ready for 3 cycles.
   - Require out_valid=1, out_data=2 stable and req_ready=0000.
   - On the cycle out_ready returns, require req_ready=0100 (ptr=2) and no bubble cycle.
4. Sparse requests: only requester 3 valid (data=9), ptr=0.
   - Require req_ready=1000 and out_data=9, out_grant=3 on the next edge, then ptr=0.
   - Then only requester 1 valid: require grant 1.
5. Idle drain: the stage is full, all req_valid=0, out_ready=1.
   - Require out_valid to fall to 0 the next cycle, with out_data held and ptr unchanged.
6. Asynchronous reset mid-stream: pulse reset between clock edges while out_valid=1.
   - Require out_valid=0 immediately without waiting for a clock edge.
   - After release, require grants restart at requester 0.
